gray_conv_arbiter: RTL and testbench
====================================

GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 Parameter WIDTH, default 4: data width of every binary and Gray value.
REQ-002 Parameter CNTW, default 8: width of the conversion counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req0_valid  input  1  requester 0 offers a binary value.
REQ-006 req0_data  input  WIDTH  requester 0 binary value.
REQ-007 req0_ready  output  1  requester 0 value accepted this cycle.
REQ-008 req1_valid  input  1  requester 1 offers a binary value.
REQ-009 req1_data  input  WIDTH  requester 1 binary value.
REQ-010 req1_ready  output  1  requester 1 value accepted this cycle.
REQ-011 out_valid  output  1  out_data/out_src hold a converted result.
REQ-012 out_data  output  WIDTH  Gray code of the accepted value.
REQ-013 out_src  output  1  index of the requester that produced out_data.
REQ-014 out_ready  input  1  consumer takes the result this cycle.
REQ-015 conv_count  output  CNTW  total results delivered since reset.

Function
REQ-016 A transfer on any channel occurs only in a cycle where valid and ready are both 1 at the rising edge.
REQ-017 Output stage is a single-entry buffer with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-018 slot_free = EMPTY, or FULL with out_ready=1 (same-cycle drain-and-refill allowed; no bubble).
REQ-019 reqN_ready is combinational: 1 only when slot_free and requester N holds the grant; at most one reqN_ready is 1 in any cycle.
REQ-020 Grant: if only one requester is valid it wins; if both are valid, the requester not granted last time wins (round-robin).
REQ-021 Grant pointer last_grant updates only on an accepted transfer; reset value points at requester 1, so requester 0 wins the first tie.
REQ-022 reqN_ready shall not depend on out_data, and the grant shall not change between cycles while slot_free=0.
REQ-023 On acceptance, out_data <= gray(reqN_data) and out_src <= N, so out_valid=1 exactly one cycle after acceptance (latency 1).
REQ-024 gray(b): MSB unchanged; bit i = b[i+1] XOR b[i] for i < WIDTH-1.
REQ-025 FULL with out_ready=0: out_data, out_src and out_valid hold stable; no requester is readied.
REQ-026 FULL with out_ready=1 and no valid request: next state EMPTY.
REQ-027 conv_count increments by 1 on each out_valid&out_ready transfer and wraps from 2^CNTW-1 to 0.
REQ-028 Inputs are never sampled while the corresponding ready is 0; a requester's offered data may change freely while unaccepted.

Reset
REQ-029 Asserting rst_n=0 at any time immediately forces state EMPTY, out_valid=0, out_data=0, out_src=0, conv_count=0, last_grant=1, with both reqN_ready=0.
REQ-030 A result pending at reset is discarded; no transfer completes in the first rising edge after rst_n deasserts unless slot_free and a valid request exist.

Structure
REQ-031 Shared package holds the state encoding (EMPTY=0, FULL=1) and requester index constants (REQ0=0, REQ1=1).
REQ-032 Conversion is one instantiated combinational sub-module, bin2gray_core (WIDTH in, WIDTH out); the arbiter contains no other conversion logic.

Verification
REQ-033 Single request: req0_valid=1, data=4'b0110, out_ready=1 -> req0_ready=1 that cycle; next cycle out_valid=1, out_data=4'b0101, out_src=0.
REQ-034 Tie after reset: both valid, req0=4'b1111, req1=4'b1000, out_ready=1 -> outputs 4'b1000 src0, then 4'b1100 src1, alternating.
REQ-035 Backpressure: FULL, out_ready=0 for 5 cycles with both requesters valid -> out_data stable, both readies 0, conv_count unchanged.
REQ-036 Streaming: req1 valid every cycle with data 0..15, out_ready=1 -> one result per cycle, Gray sequence 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8.
REQ-037 Counter wrap: 256 delivered results -> conv_count returns to 0.
REQ-038 Mid-operation reset: rst_n=0 while FULL with out_ready=0 -> out_valid=0 and conv_count=0 immediately; after release, first tie goes to requester 0.

Source files
------------

// File: rtl/gray_conv_arbiter_pkg.sv
// gray_conv_arbiter_pkg
// Shared definitions for the Gray-conversion arbiter slice.
//   state_t : output buffer occupancy (EMPTY / FULL)
//   REQ0/1  : requester index constants, used for the grant and out_src
package gray_conv_arbiter_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/gray_conv_arbiter_bin2gray.sv
// bin2gray_core
// Purely combinational binary-to-Gray converter.
// Ports:
//   bin  : binary input value (WIDTH bits)
//   gray : Gray-coded result; MSB passes through, every lower bit is the
//          XOR of itself and its upper neighbour.
module bin2gray_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray[WIDTH-1] = bin[WIDTH-1];

  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_xor
      assign gray[gi] = bin[gi+1] ^ bin[gi];
    end
  endgenerate

endmodule

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter
// Two requesters offer binary values; a round-robin arbiter picks one,
// converts it to Gray code and stores it in a single-entry output buffer.
// The buffer can be drained and refilled in the same cycle, so a
// continuously ready consumer sees one result per clock.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   reqN_valid/data/ready   : requester N handshake (N = 0, 1)
//   out_valid/data/src      : buffered Gray result and its source index
//   out_ready               : consumer accepts the buffered result
//   conv_count              : results delivered since reset (wraps)
module gray_conv_arbiter
  import gray_conv_arbiter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic [CNTW-1:0]  conv_count
);

  state_t            state_reg;
  logic              last_grant_reg;
  logic [WIDTH-1:0]  out_data_reg;
  logic              out_src_reg;
  logic [CNTW-1:0]   conv_count_reg;

  logic              slot_free;
  logic              grant;
  logic              accept;
  logic              deliver;
  logic [WIDTH-1:0]  sel_data;
  logic [WIDTH-1:0]  gray_value;
  logic [CNTW-1:0]   conv_count_next;

  // Grant depends only on the valids and the registered pointer, so it
  // cannot move while the buffer is blocked unless a requester withdraws.
  always_comb begin
    // rst_n is folded in so that neither requester is readied while reset
    // is held, even if the consumer is asserting out_ready.
    slot_free = rst_n && ((state_reg == EMPTY) || out_ready);
    grant     = REQ0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_reg;
    end else if (req1_valid) begin
      grant = REQ1;
    end
  end

  assign req0_ready = slot_free && req0_valid && (grant == REQ0);
  assign req1_ready = slot_free && req1_valid && (grant == REQ1);

  assign accept  = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign deliver = (state_reg == FULL) && out_ready;

  assign sel_data        = (grant == REQ1) ? req1_data : req0_data;
  assign conv_count_next = conv_count_reg + CNTW'(1);

  bin2gray_core #(
    .WIDTH(WIDTH)
  ) u_bin2gray_core (
    .bin  (sel_data),
    .gray (gray_value)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= EMPTY;
      last_grant_reg <= REQ1;
      out_data_reg   <= '0;
      out_src_reg    <= REQ0;
      conv_count_reg <= '0;
    end else begin
      if (accept) begin
        // Covers both a fill from EMPTY and a drain-and-refill from FULL.
        state_reg      <= FULL;
        out_data_reg   <= gray_value;
        out_src_reg    <= grant;
        last_grant_reg <= grant;
      end else if (deliver) begin
        state_reg <= EMPTY;
      end
      if (deliver) begin
        conv_count_reg <= conv_count_next;
      end
    end
  end

  assign out_valid  = (state_reg == FULL);
  assign out_data   = out_data_reg;
  assign out_src    = out_src_reg;
  assign conv_count = conv_count_reg;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb_gray_conv_arbiter
// Directed stimulus with hand-computed Gray values. The driver predicts
// handshakes and pushes expected results into a scoreboard queue; a
// separate monitor compares whatever the DUT presents on the output.
module tb_gray_conv_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req0_valid = 1'b0;
  logic [3:0] req0_data = 4'h0;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [3:0] req1_data = 4'h0;
  logic       req1_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_src;
  logic       out_ready = 1'b0;
  logic [7:0] conv_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] data;
    logic       src;
  } exp_t;

  exp_t sb_q[$];

  // Committed model state (valid after the last edge) and pending state
  // (what the next edge is predicted to produce).
  bit       m_full, m_last;
  bit [7:0] m_count;
  bit       p_full, p_last;
  bit [7:0] p_count;

  bit [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  always #5 clk = ~clk;

  gray_conv_arbiter #(
    .WIDTH(4),
    .CNTW (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .conv_count (conv_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: samples on the falling edge, halfway between active edges.
  // A held result is compared every cycle, which also proves it is stable
  // under backpressure; it is popped only when the consumer takes it.
  always @(negedge clk) begin
    if (rst_n && out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0h src=%0d required=none", out_data, out_src);
      end else begin
        check("out_data", out_data, sb_q[0].data);
        check("out_src", out_src, sb_q[0].src);
        if (out_ready === 1'b1) begin
          $display("result src=%0d data=%h count_before=%0d", out_src, out_data, conv_count);
          void'(sb_q.pop_front());
        end
      end
    end
  end

  // One clock of stimulus. g0/g1 are the hand-computed Gray codes of d0/d1.
  task automatic cycle(input bit v0, input bit [3:0] d0, input bit [3:0] g0,
                       input bit v1, input bit [3:0] d1, input bit [3:0] g1,
                       input bit ordy);
    bit sf, gr, e0, e1;
    @(posedge clk);
    m_full  = p_full;
    m_last  = p_last;
    m_count = p_count;
    #2;
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    out_ready  = ordy;
    #1;
    check("out_valid", out_valid, m_full);
    check("conv_count", conv_count, m_count);
    sf = !m_full || ordy;
    gr = (v0 && v1) ? !m_last : v1;
    e0 = sf && v0 && !gr;
    e1 = sf && v1 && gr;
    check("req0_ready", req0_ready, e0);
    check("req1_ready", req1_ready, e1);
    if (m_full && ordy) begin
      p_full  = 1'b0;
      p_count = m_count + 8'd1;
    end
    if (e0 || e1) begin
      sb_q.push_back('{data: (gr ? g1 : g0), src: gr});
      p_full = 1'b1;
      p_last = gr;
    end
  endtask

  task automatic idle(input bit ordy);
    cycle(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, ordy);
  endtask

  // Reset asserted mid-cycle with both requesters valid and the consumer
  // ready: everything must clear at once and no requester may be readied.
  task automatic do_reset();
    @(posedge clk);
    #4;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    out_ready  = 1'b1;
    rst_n      = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 4'h0);
    check("rst_out_src", out_src, 1'b0);
    check("rst_conv_count", conv_count, 8'd0);
    check("rst_req0_ready", req0_ready, 1'b0);
    check("rst_req1_ready", req1_ready, 1'b0);
    sb_q.delete();
    m_full = 1'b0; m_last = 1'b1; m_count = 8'd0;
    p_full = 1'b0; p_last = 1'b1; p_count = 8'd0;
    repeat (2) @(posedge clk);
    #2;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready  = 1'b0;
    rst_n      = 1'b1;
  endtask

  initial begin
    do_reset();

    // Tie after reset: 1111 -> 1000 (src0), 1000 -> 1100 (src1), alternating.
    repeat (2) begin
      cycle(1'b1, 4'hF, 4'h8, 1'b1, 4'h8, 4'hC, 1'b1);
      cycle(1'b1, 4'hF, 4'h8, 1'b1, 4'h8, 4'hC, 1'b1);
    end
    idle(1'b1);

    // Single request: 0110 -> 0101 from requester 0.
    cycle(1'b1, 4'h6, 4'h5, 1'b0, 4'h0, 4'h0, 1'b1);
    idle(1'b1);

    // Backpressure: fill, hold 5 cycles with both valid, then drain+refill.
    cycle(1'b1, 4'h3, 4'h2, 1'b0, 4'h0, 4'h0, 1'b1);
    repeat (5) cycle(1'b1, 4'h3, 4'h2, 1'b1, 4'h5, 4'h7, 1'b0);
    cycle(1'b1, 4'h3, 4'h2, 1'b1, 4'h5, 4'h7, 1'b1);
    idle(1'b1);

    // Streaming 0..15 on requester 1, one result per cycle.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 4'h0, 4'h0, 1'b1, 4'(i), gray_tab[i], 1'b1);
    end
    idle(1'b1);

    // Mid-operation reset with a result stuck in the buffer.
    cycle(1'b1, 4'hA, 4'hF, 1'b0, 4'h0, 4'h0, 1'b1);
    idle(1'b0);
    idle(1'b0);
    do_reset();
    cycle(1'b1, 4'hF, 4'h8, 1'b1, 4'h8, 4'hC, 1'b1);
    cycle(1'b1, 4'hF, 4'h8, 1'b1, 4'h8, 4'hC, 1'b1);
    idle(1'b1);

    // Counter wrap: 256 deliveries from a zeroed counter.
    do_reset();
    for (int k = 0; k < 256; k++) begin
      cycle(1'b0, 4'h0, 4'h0, 1'b1, 4'(k), gray_tab[k % 16], 1'b1);
    end
    idle(1'b1);
    idle(1'b0);
    @(posedge clk);
    #3;
    check("conv_count_wrap", conv_count, 8'd0);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
